text_pixel_blender: RTL and testbench



---
 rtl/text_pixel_blender.sv | 110 +++++++++++
 tb/tb_text_pixel_blender.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/text_pixel_blender.sv
// text_pixel_blender: font-RAM glyph lookup and alpha blend over the layer background, one pixel per clock.
// Define TEXT_PIXEL_BLENDER_OUTREG_EN to add an output register stage (latency 3 instead of 2).
module text_pixel_blender #(
  parameter string FONT_FILE = "../font/font8x8.bits"
) (
  input  logic        i_clk,
  input  logic        i_nrst,
  input  logic [7:0]  i_char,
  input  logic [2:0]  i_row,
  input  logic [2:0]  i_column,
  input  logic [11:0] i_fg_color,
  input  logic [11:0] i_cell_bg_color,
  input  logic [11:0] i_bg_color,
  input  logic [2:0]  i_alpha,
  input  logic        i_font_we,
  input  logic [10:0] i_font_addr,
  input  logic [7:0]  i_font_data,
  output logic [11:0] o_color
);

  logic [7:0]  r_font_mem [0:2047];

  logic [7:0]  r_font_byte_p1;
  logic [2:0]  r_column_p1;
  logic [11:0] r_fg_p1;
  logic [11:0] r_cell_bg_p1;
  logic [11:0] r_bg_p1;
  logic [2:0]  r_alpha_p1;

  logic        w_pix_on;
  logic [11:0] w_inter;
  logic [3:0]  w_weight;
  logic [11:0] w_blend;

  logic [11:0] r_color_p2;

  // Alpha code to weight in eighths; code 7 is reserved and behaves as opaque.
  function automatic logic [3:0] alpha_weight(input logic [2:0] code);
    logic [3:0] w;
    case (code)
      3'd0:    w = 4'd0;
      3'd1:    w = 4'd1;
      3'd2:    w = 4'd2;
      3'd3:    w = 4'd3;
      3'd4:    w = 4'd4;
      3'd5:    w = 4'd6;
      default: w = 4'd8;
    endcase
    return w;
  endfunction

  // One 4-bit component: (inter*w + bg*(8-w)) >> 3, truncated; the sum never exceeds 120.
  function automatic logic [3:0] blend_comp(input logic [3:0] inter, input logic [3:0] bg,
                                            input logic [3:0] w);
    logic [7:0] sum;
    sum = ({4'd0, inter} * {4'd0, w}) + ({4'd0, bg} * (8'd8 - {4'd0, w}));
    return 4'(sum >> 3);
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_font_we) r_font_mem[i_font_addr] <= i_font_data;
  end

  // Stage 1: synchronous font read (old data on a same-address write) and operand capture
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) begin
      r_font_byte_p1 <= 8'h00;
      r_column_p1    <= 3'd0;
      r_fg_p1        <= 12'h000;
      r_cell_bg_p1   <= 12'h000;
      r_bg_p1        <= 12'h000;
      r_alpha_p1     <= 3'd0;
    end else begin
      r_font_byte_p1 <= r_font_mem[{i_char, i_row}];
      r_column_p1    <= i_column;
      r_fg_p1        <= i_fg_color;
      r_cell_bg_p1   <= i_cell_bg_color;
      r_bg_p1        <= i_bg_color;
      r_alpha_p1     <= i_alpha;
    end
  end

  assign w_pix_on = r_font_byte_p1[3'd7 - r_column_p1];
  assign w_inter  = w_pix_on ? r_fg_p1 : r_cell_bg_p1;
  assign w_weight = alpha_weight(r_alpha_p1);
  assign w_blend  = {blend_comp(w_inter[11:8], r_bg_p1[11:8], w_weight),
                     blend_comp(w_inter[7:4],  r_bg_p1[7:4],  w_weight),
                     blend_comp(w_inter[3:0],  r_bg_p1[3:0],  w_weight)};

  // Stage 2: pixel select and blend result
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r_color_p2 <= 12'h000;
    else         r_color_p2 <= w_blend;
  end

`ifdef TEXT_PIXEL_BLENDER_OUTREG_EN
  logic [11:0] r_color_p3;

  // Stage 3: optional output register
  always_ff @(posedge i_clk or negedge i_nrst) begin
    if (!i_nrst) r_color_p3 <= 12'h000;
    else         r_color_p3 <= r_color_p2;
  end

  assign o_color = r_color_p3;
`else
  assign o_color = r_color_p2;
`endif

endmodule

// File: tb/tb_text_pixel_blender.sv
// Scoreboard bench for text_pixel_blender: directed scenarios plus randomized pixels and font writes.
module tb_text_pixel_blender;
`ifdef TEXT_PIXEL_BLENDER_OUTREG_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic        clk = 1'b0;
  logic        nrst;
  logic [7:0]  chr;
  logic [2:0]  row;
  logic [2:0]  col;
  logic [11:0] fg;
  logic [11:0] cbg;
  logic [11:0] bg;
  logic [2:0]  alpha;
  logic        font_we;
  logic [10:0] font_addr;
  logic [7:0]  font_data;
  logic [11:0] o_color;

  logic [7:0]  fm [0:2047];
  logic [11:0] exp_q [$];
  string       name_q [$];
  logic        vin;
  logic [LAT-1:0] vld_d;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  text_pixel_blender #(.FONT_FILE("")) dut (
    .i_clk(clk), .i_nrst(nrst), .i_char(chr), .i_row(row), .i_column(col),
    .i_fg_color(fg), .i_cell_bg_color(cbg), .i_bg_color(bg), .i_alpha(alpha),
    .i_font_we(font_we), .i_font_addr(font_addr), .i_font_data(font_data),
    .o_color(o_color)
  );

  task automatic check(input string nm, input logic [11:0] act, input logic [11:0] exp_c);
    checks++;
    if (act !== exp_c) begin
      errors++;
      $display("FAIL %s: got %03h expected %03h at %0t", nm, act, exp_c, $time);
    end
  endtask

  // Reference: pick glyph bit, weight table, integer blend per 4-bit component.
  function automatic logic [11:0] model(input logic [7:0] c, input logic [2:0] r, input logic [2:0] x,
                                        input logic [11:0] f, input logic [11:0] cb,
                                        input logic [11:0] b, input logic [2:0] a);
    int wt [8] = '{0, 1, 2, 3, 4, 6, 8, 8};
    logic [7:0] byt;
    logic [11:0] inter;
    int w, ic, bc, res;
    byt = fm[{c, r}];
    inter = byt[7 - int'(x)] ? f : cb;
    w = wt[a];
    res = 0;
    for (int k = 0; k < 3; k++) begin
      ic = int'(inter[4*k +: 4]);
      bc = int'(b[4*k +: 4]);
      res += ((ic * w + bc * (8 - w)) / 8) << (4 * k);
    end
    return res[11:0];
  endfunction

  // Bench-side latency tracker; reset discards in-flight tokens like the DUT.
  always @(posedge clk or negedge nrst) begin
    if (!nrst) vld_d <= '0;
    else       vld_d <= LAT'({vld_d, vin});
  end

  always @(negedge clk) begin
    if (nrst && vld_d[LAT-1]) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL scoreboard_underflow: got %03h expected none", o_color);
      end else begin
        check(name_q.pop_front(), o_color, exp_q.pop_front());
      end
    end
  end

  task automatic wr(input logic [10:0] a, input logic [7:0] d);
    font_we = 1'b1; font_addr = a; font_data = d;
    fm[a] = d;
    @(posedge clk); #1;
    font_we = 1'b0;
  endtask

  task automatic send(input string nm, input logic [7:0] c, input logic [2:0] r, input logic [2:0] x,
                      input logic [11:0] f, input logic [11:0] cb, input logic [11:0] b,
                      input logic [2:0] a, input logic use_exp, input logic [11:0] exp_c);
    chr = c; row = r; col = x; fg = f; cbg = cb; bg = b; alpha = a; vin = 1'b1;
    exp_q.push_back(use_exp ? exp_c : model(c, r, x, f, cb, b, a));
    name_q.push_back(nm);
    @(posedge clk); #1;
    vin = 1'b0; font_we = 1'b0;
  endtask

  task automatic std_px(input string nm, input logic [2:0] x, input logic [2:0] a, input logic [11:0] e);
    send(nm, 8'h41, 3'd0, x, 12'hF00, 12'h00F, 12'h0F0, a, 1'b1, e);
  endtask

  initial begin
    logic [7:0] rc; logic [2:0] rr, rx, ra; logic [11:0] rf, rcb, rb;
    logic [10:0] wa; logic [7:0] wd; logic do_wr;
    nrst = 1'b0; vin = 1'b0; font_we = 1'b0; font_addr = '0; font_data = '0;
    chr = '0; row = '0; col = '0; fg = '0; cbg = '0; bg = '0; alpha = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", o_color, 12'h000);
    nrst = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 2048; i++) wr(11'(i), 8'($urandom));
    wr({8'h41, 3'd0}, 8'h80);

    std_px("opaque_glyph", 3'd0, 3'd6, 12'hF00);
    std_px("opaque_cell_bg", 3'd1, 3'd6, 12'h00F);
    std_px("alpha0", 3'd0, 3'd0, 12'h0F0);
    std_px("alpha7", 3'd0, 3'd7, 12'hF00);
    std_px("alpha4", 3'd0, 3'd4, 12'h770);
    std_px("alpha5", 3'd0, 3'd5, 12'hB30);
    for (int x = 0; x < 8; x++)
      std_px("stream", 3'(x), 3'd6, (x == 0) ? 12'hF00 : 12'h00F);

    // Random pixels, some with concurrent font writes (same address sometimes).
    for (int i = 0; i < 600; i++) begin
      rc = 8'($urandom); rr = 3'($urandom); rx = 3'($urandom); ra = 3'($urandom);
      rf = 12'($urandom); rcb = 12'($urandom); rb = 12'($urandom);
      do_wr = ($urandom_range(0, 9) < 3);
      wa = ($urandom_range(0, 1) == 1) ? {rc, rr} : 11'($urandom);
      if (wa == 11'h208) wa = 11'h209;
      wd = 8'($urandom);
      if (do_wr) begin
        font_we = 1'b1; font_addr = wa; font_data = wd;
      end
      send("random", rc, rr, rx, rf, rcb, rb, ra, 1'b0, 12'h000);
      if (do_wr) fm[wa] = wd;
    end

    for (int x = 0; x < 4; x++) std_px("pre_reset", 3'(x), 3'd6, (x == 0) ? 12'hF00 : 12'h00F);
    #1;
    nrst = 1'b0;
    exp_q.delete();
    name_q.delete();
    #1;
    check("reset_async", o_color, 12'h000);
    repeat (3) @(posedge clk);
    #1;
    check("reset_hold", o_color, 12'h000);
    nrst = 1'b1;
    std_px("after_reset", 3'd0, 3'd6, 12'hF00);
    std_px("after_reset_bg", 3'd2, 3'd6, 12'h00F);

    for (int t = 0; t < 10 && exp_q.size() != 0; t++) @(posedge clk);
    @(negedge clk); #1;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
